// File: rtl/bcd_convert_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// Accept->done latency IN_WIDTH+1 cycles; start ignored while busy; results hold between conversions.
module bcd_convert_seq #(
  parameter  int IN_WIDTH   = 16,
  parameter  int NUM_DIGITS = 5,
  localparam int CNT_W      = $clog2(NUM_DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [IN_WIDTH-1:0]     number,
  input  logic                    is_signed,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] digits_flat,
  output logic [CNT_W-1:0]        num_digits,
  output logic                    negative,
  output logic                    overflow
);

  localparam int BW   = 4 * NUM_DIGITS;
  localparam int BITW = $clog2(IN_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [IN_WIDTH-1:0] mag_q;
  logic [BW-1:0]       acc_q;
  logic [BITW-1:0]     cnt_q;
  logic                neg_q;
  logic                ovf_q;

  logic [BW-1:0]       digits_q;
  logic [CNT_W-1:0]    ndig_q;
  logic                negative_q;
  logic                overflow_q;
  logic                done_q;

  logic                load_en;
  logic                shift_en;
  logic                fin_en;
  logic [BW-1:0]       acc_adj;
  logic [CNT_W-1:0]    ndig_c;
  logic [IN_WIDTH-1:0] mag_in;
  logic                neg_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_SHIFT;
      S_SHIFT:  if (cnt_q == BITW'(1)) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_en  = 1'b0;
    shift_en = 1'b0;
    fin_en   = 1'b0;
    busy     = 1'b0;
    case (state_q)
      S_IDLE:   load_en = start;
      S_SHIFT:  begin shift_en = 1'b1; busy = 1'b1; end
      S_FINISH: begin fin_en = 1'b1;   busy = 1'b1; end
      default:  ;
    endcase
  end

  // Signed negative inputs are converted as their magnitude; the most negative value maps to 2^(IN_WIDTH-1).
  assign neg_in = is_signed & number[IN_WIDTH-1];
  assign mag_in = neg_in ? (~number + IN_WIDTH'(1)) : number;

  always_comb begin
    acc_adj = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      acc_adj[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ? (acc_q[4*i +: 4] + 4'd3) : acc_q[4*i +: 4];
    end
  end

  always_comb begin
    ndig_c = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (acc_q[4*i +: 4] != 4'd0) ndig_c = CNT_W'(i + 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
      digits_q   <= '0;
      ndig_q     <= '0;
      negative_q <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= fin_en;
      if (load_en) begin
        mag_q <= mag_in;
        acc_q <= '0;
        cnt_q <= BITW'(IN_WIDTH);
        neg_q <= neg_in;
        ovf_q <= 1'b0;
      end else if (shift_en) begin
        {acc_q, mag_q} <= {acc_adj[BW-2:0], mag_q, 1'b0};
        cnt_q          <= cnt_q - BITW'(1);
        if (acc_adj[BW-1]) ovf_q <= 1'b1;
      end
      if (fin_en) begin
        digits_q   <= acc_q;
        ndig_q     <= ndig_c;
        negative_q <= neg_q;
        overflow_q <= ovf_q;
      end
    end
  end

  assign done        = done_q;
  assign digits_flat = digits_q;
  assign num_digits  = ndig_q;
  assign negative    = negative_q;
  assign overflow    = overflow_q;

endmodule
